rom_loader: RTL and testbench
=============================

Name: rom_loader

Overview:
Writer side of the 32-word ROM/program memory. It accepts a byte stream over a valid/ready handshake and packs every 4 bytes into one 32-bit word, little-endian. It then issues one write strobe per word at consecutive addresses 0..DEPTH-1 and signals done when the image is complete. It sits between a byte source (UART/bench) and the memory's write port; the existing address-counter read path consumes the loaded image afterwards.

Parameters:
DEPTH, 32, number of 32-bit words in the target memory (image = 4*DEPTH bytes)
ADDR_W, 32, width of wr_addr (matches memory address width)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (rst=0 resets immediately)
start  input  1  begin a load; sampled only in IDLE or DONE
abort  input  1  cancel a load in progress
in_valid  input  1  byte source has in_data valid
in_data  input  8  byte from source
in_ready  output  1  loader accepts a byte this cycle
wr_en  output  1  one-cycle memory write strobe
wr_addr  output  ADDR_W  word address of the write
wr_data  output  32  packed word
busy  output  1  high in LOAD or WRITE
done  output  1  high in DONE (image complete)

Behaviour:
- State machine states: IDLE, LOAD, WRITE, DONE. All outputs are registered or decoded from state.
- Reset (rst=0, async): state=IDLE, byte_idx=0, word_addr=0, shift reg=0; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
- IDLE: in_ready=0. start=1 → LOAD; byte_idx and word_addr are cleared to 0.
- LOAD: in_ready=1, busy=1.
  - A byte transfers only when in_valid & in_ready at a rising edge.
  - Byte k (k=0..3) of the current word goes to bits [8k+7:8k].
  - in_valid=0 holds state; gaps of any length are legal.
  - A transfer with byte_idx=3 → WRITE on that edge.
- WRITE: lasts exactly 1 cycle.
  - wr_en=1, wr_addr=word_addr, wr_data=assembled word; in_ready=0, busy=1.
  - Latency: the 4th byte accepted at edge N gives wr_en high during the cycle after edge N.
  - Next state: if word_addr==DEPTH-1 → DONE; otherwise word_addr+1 and byte_idx=0 → LOAD.
  - Peak throughput is 1 word per 5 cycles.
- DONE: done=1, in_ready=0, busy=0. Held until start=1, which restarts exactly as from IDLE (done drops on that edge).
- wr_addr/wr_data hold their last values when wr_en=0. Consumers must qualify them with wr_en.
- abort=1 in LOAD: → IDLE at the next edge. Partial word is discarded (no write), byte_idx=0, word_addr=0, done=0. A byte presented in the same cycle is not accepted: in_ready is forced 0 combinationally when abort=1.
- abort in WRITE: the write completes, then → IDLE instead of LOAD/DONE.
- abort in IDLE/DONE: ignored.
- start while busy: ignored.
- start and abort both high in IDLE/DONE: start wins.
- word_addr never exceeds DEPTH-1; there is no wrap-around write past the end.
- Reset asserted mid-load: immediate return to the reset values above. No wr_en pulse may be emitted during or after reset until a new start.

Test Plan:
- Reset values: hold rst=0, drive random inputs → all outputs 0, in_ready=0. Release rst with start=0 → stays IDLE.
- Full load: start, then bytes 0x00..0x7F back-to-back with in_valid=1 → exactly 32 wr_en pulses.
  - Addresses 0..31; word0=0x03020100, word31=0x7F7E7D7C.
  - 5-cycle spacing between pulses; done=1 the cycle after the last write; in_ready=0 in DONE.
- Gapped source: insert random in_valid=0 gaps between bytes → identical write addresses and data as the full load. No byte is lost or duplicated (checked against a scoreboard).
- Abort: start, send 0xAA, 0xBB, assert abort → no wr_en. Restart and send 0x11,0x22,0x33,0x44 → first write addr 0, data 0x44332211.
- Start ignored / restart: pulse start during LOAD → word_addr unaffected. After DONE, start → done drops and reload begins at addr 0.
- Async reset mid-word: assert rst=0 between clock edges after 2 bytes of word 5 → outputs clear before the next edge, no spurious wr_en. A new load writes from addr 0.

Source files
------------

// File: rtl/rom_loader.sv
// Byte-stream loader for the program memory: packs 4 bytes little-endian into
// a 32-bit word and writes words to consecutive addresses 0..DEPTH-1.
module rom_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state_r;
    logic [1:0]          byte_idx_r;
    logic [ADDR_W-1:0]   word_addr_r;
    logic [31:0]         shift_r;
    logic                wr_en_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [31:0]         wr_data_r;
    logic                ready_s;
    logic                xfer_s;

    // abort must block a same-cycle byte, so ready cannot wait for the state change
    assign ready_s  = (state_r == LOAD) && !abort;
    assign xfer_s   = ready_s && in_valid;

    assign in_ready = ready_s;
    assign wr_en    = wr_en_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;
    assign busy     = (state_r == LOAD) || (state_r == WRITE);
    assign done     = (state_r == DONE);

    // Load sequencer: byte packing, write strobe generation and image addressing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            byte_idx_r  <= 2'd0;
            word_addr_r <= '0;
            shift_r     <= 32'd0;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= 32'd0;
        end else begin
            wr_en_r <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r     <= LOAD;
                        byte_idx_r  <= 2'd0;
                        word_addr_r <= '0;
                        shift_r     <= 32'd0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state_r     <= IDLE;
                        byte_idx_r  <= 2'd0;
                        word_addr_r <= '0;
                        shift_r     <= 32'd0;
                    end else if (xfer_s) begin
                        shift_r[{byte_idx_r, 3'b000} +: 8] <= in_data;
                        byte_idx_r <= byte_idx_r + 2'd1;
                        if (byte_idx_r == 2'd3) begin
                            state_r   <= WRITE;
                            wr_en_r   <= 1'b1;
                            wr_addr_r <= word_addr_r;
                            wr_data_r <= {in_data, shift_r[23:0]};
                        end else begin
                            state_r <= LOAD;
                        end
                    end else begin
                        state_r <= LOAD;
                    end
                end
                WRITE: begin
                    byte_idx_r <= 2'd0;
                    if (abort) begin
                        state_r     <= IDLE;
                        word_addr_r <= '0;
                        shift_r     <= 32'd0;
                    end else if (word_addr_r == LAST_ADDR) begin
                        state_r <= DONE;
                    end else begin
                        state_r     <= LOAD;
                        word_addr_r <= word_addr_r + ADDR_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Directed self-checking bench for rom_loader: reset, full/gapped loads,
// abort, ignored start, restart and asynchronous reset mid-word.
module tb_rom_loader;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    int done_cyc = 0;
    logic done_prev = 1'b0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];

    rom_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every write strobe and the first cycle of each done assertion
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            wc_q.push_back(cyc);
        end
        if (done === 1'b1 && !done_prev) done_cyc = cyc;
        done_prev = (done === 1'b1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int   t;
        logic ok;
        in_valid = 1'b0;
        repeat (gap) begin
            in_data = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        t  = 0;
        ok = 1'b0;
        while (!ok && t < 20) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        if (!ok) check("handshake_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (done !== 1'b1 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (done !== 1'b1) check(tag, 64'(done), 64'd1);
    endtask

    task automatic wait_writes(input int n, input string tag);
        int t = 0;
        while (wa_q.size() < n && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (wa_q.size() < n) check(tag, 64'(wa_q.size()), 64'(n));
    endtask

    task automatic check_image(input string tag);
        logic [31:0] exp;
        int          bad = 0;
        check({tag, "_count"}, 64'(wa_q.size()), 64'd32);
        for (int i = 0; i < DEPTH && i < wa_q.size(); i++) begin
            exp = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            if (wa_q[i] !== 32'(i) || wd_q[i] !== exp) begin
                bad++;
                check({tag, "_word"}, {wa_q[i], wd_q[i]}, {32'(i), exp});
            end
        end
        check({tag, "_words_bad"}, 64'(bad), 64'd0);
    endtask

    initial begin
        int gaps_bad;
        rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'd0;

        // reset with random inputs: everything must read zero
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            start = 1'($urandom); abort = 1'($urandom);
            in_valid = 1'($urandom); in_data = 8'($urandom);
            @(negedge clk);
            check("rst_flags", {in_ready, wr_en, busy, done}, 64'd0);
            check("rst_bus", {wr_addr, wr_data}, 64'd0);
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_rst", {in_ready, wr_en, busy, done}, 64'd0);

        // full back-to-back load
        clear_q();
        pulse_start();
        check("load_busy", {busy, in_ready}, 64'b11);
        for (int i = 0; i < 4*DEPTH; i++) send_byte(8'(i), 0);
        wait_done("full_done_timeout");
        repeat (3) @(posedge clk);
        #1;
        check_image("full");
        check("full_word0", 64'(wd_q[0]), 64'h0302_0100);
        check("full_word31", 64'(wd_q[31]), 64'h7F7E_7D7C);
        gaps_bad = 0;
        for (int i = 1; i < wc_q.size(); i++)
            if (wc_q[i] - wc_q[i-1] != 5) gaps_bad++;
        check("full_spacing", 64'(gaps_bad), 64'd0);
        check("done_latency", 64'(done_cyc - wc_q[wc_q.size()-1]), 64'd1);
        check("done_state", {done, busy, in_ready, wr_en}, 64'b1000);

        // restart from DONE with a gapped source
        clear_q();
        pulse_start();
        check("restart_done_drop", {done, busy}, 64'b01);
        for (int i = 0; i < 4*DEPTH; i++) send_byte(8'(i), int'($urandom_range(0, 3)));
        wait_done("gap_done_timeout");
        repeat (3) @(posedge clk);
        #1;
        check_image("gapped");

        // abort with a partial word and a byte offered in the same cycle
        clear_q();
        pulse_start();
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        abort = 1'b1; in_valid = 1'b1; in_data = 8'hCC;
        @(negedge clk);
        check("abort_blocks_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_write", 64'(wa_q.size()), 64'd0);
        check("abort_idle", {busy, done}, 64'd0);

        pulse_start();
        send_byte(8'h11, 0); send_byte(8'h22, 1); send_byte(8'h33, 0); send_byte(8'h44, 2);
        wait_writes(1, "after_abort_timeout");
        check("after_abort_w0", {wa_q[0], wd_q[0]}, {32'd0, 32'h4433_2211});

        // start while loading is ignored: next word still lands at address 1
        pulse_start();
        send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
        wait_writes(2, "start_ignored_timeout");
        check("start_ignored_w1", {wa_q[1], wd_q[1]}, {32'd1, 32'h8877_6655});

        // words 2..4, then two bytes of word 5, then asynchronous reset between edges
        for (int i = 0; i < 12; i++) send_byte(8'(8'h90 + i), 0);
        wait_writes(5, "pre_rst_timeout");
        check("pre_rst_w4", {wa_q[4], wd_q[4]}, {32'd4, 32'h9B9A_9998});
        send_byte(8'hE0, 0);
        send_byte(8'hE1, 0);
        clear_q();
        #2 rst = 1'b0;
        in_valid = 1'b1; in_data = 8'hE2;
        #1;
        check("async_rst_flags", {in_ready, wr_en, busy, done}, 64'd0);
        check("async_rst_bus", {wr_addr, wr_data}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_no_write", 64'(wa_q.size()), 64'd0);
        check("post_rst_idle", {busy, done, in_ready}, 64'd0);

        pulse_start();
        send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
        wait_writes(1, "post_rst_load_timeout");
        check("post_rst_w0", {wa_q[0], wd_q[0]}, {32'd0, 32'hEFBE_ADDE});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
